// File: rtl/bcd_ex3_pkg.sv
// Shared constants and state encoding for the serial BCD <-> Excess-3 converter.
package bcd_ex3_pkg;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] EX3_OFFSET = 4'd3;
  localparam logic [DIGIT_W-1:0] BCD_MAX    = 4'd9;
  localparam logic [DIGIT_W-1:0] EX3_MIN    = 4'd3;
  localparam logic [DIGIT_W-1:0] EX3_MAX    = 4'd12;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CONV = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/ex3_digit_xlate.sv
// Single-digit translator: BCD -> Excess-3 (mode 0) or Excess-3 -> BCD (mode 1).
module ex3_digit_xlate
  import bcd_ex3_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic               mode,
  output logic [DIGIT_W-1:0] result,
  output logic               err
);

  // Invalid codes produce zero with the error flag raised.
  always_comb begin
    result = '0;
    err    = 1'b0;
    if (!mode) begin
      if (digit <= BCD_MAX) result = digit + EX3_OFFSET;
      else                  err    = 1'b1;
    end else begin
      if (digit >= EX3_MIN && digit <= EX3_MAX) result = digit - EX3_OFFSET;
      else                                       err    = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_ex3_serial_conv.sv
// Word-level BCD/Excess-3 converter that reuses one digit translator,
// processing one digit per cycle with valid/ready handshakes on both sides.
module bcd_ex3_serial_conv
  import bcd_ex3_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIGIT_W*DIGITS-1:0] in_data,
  input  logic                      mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIGIT_W*DIGITS-1:0] out_data,
  output logic [DIGITS-1:0]         out_err_mask,
  output logic                      out_err
);

  localparam int unsigned W     = DIGIT_W * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_t             state;
  state_t             state_nxt;
  logic [W-1:0]       data_q;
  logic               mode_q;
  logic [IDX_W-1:0]   idx;
  logic [DIGIT_W-1:0] cur_digit;
  logic [DIGIT_W-1:0] cur_res;
  logic               cur_err;
  logic [DIGITS-1:0]  mask_nxt;
  logic               last_digit;

  assign cur_digit  = data_q[idx*DIGIT_W +: DIGIT_W];
  assign last_digit = (idx == LAST_IDX);
  assign in_ready   = (state == ST_IDLE) && !rst;

  ex3_digit_xlate u_xlate (
    .digit  (cur_digit),
    .mode   (mode_q),
    .result (cur_res),
    .err    (cur_err)
  );

  always_comb begin
    mask_nxt      = out_err_mask;
    mask_nxt[idx] = cur_err;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)   state_nxt = ST_CONV;
      ST_CONV: if (last_digit) state_nxt = ST_DONE;
      ST_DONE: if (out_ready)  state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  // Capture, per-digit write-back and result handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q       <= '0;
      mode_q       <= 1'b0;
      idx          <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_err_mask <= '0;
      out_err      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            data_q <= in_data;
            mode_q <= mode;
            idx    <= '0;
          end
        end
        ST_CONV: begin
          out_data[idx*DIGIT_W +: DIGIT_W] <= cur_res;
          out_err_mask                     <= mask_nxt;
          out_err                          <= |mask_nxt;
          if (last_digit) out_valid <= 1'b1;
          else            idx       <= idx + IDX_W'(1);
        end
        ST_DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_ex3_serial_conv.sv
// Directed self-checking bench for bcd_ex3_serial_conv with DIGITS=4.
module tb_bcd_ex3_serial_conv;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_err_mask;
  logic        out_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bcd_ex3_serial_conv #(.DIGITS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .mode         (mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_err_mask (out_err_mask),
    .out_err      (out_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference conversion: returns {mask, data}.
  function automatic logic [19:0] ref_conv(input logic [15:0] d, input logic m);
    logic [15:0] o;
    logic [3:0]  msk;
    logic [3:0]  dig;
    o   = '0;
    msk = '0;
    for (int i = 0; i < 4; i++) begin
      dig = d[4*i +: 4];
      if (m == 1'b0 && dig < 4'd10)
        o[4*i +: 4] = dig + 4'd3;
      else if (m == 1'b1 && dig > 4'd2 && dig < 4'd13)
        o[4*i +: 4] = dig - 4'd3;
      else
        msk[i] = 1'b1;
    end
    return {msk, o};
  endfunction

  task automatic accept(input string tag, input logic [15:0] d, input logic m);
    int k;
    k = 0;
    while (!in_ready && k < 20) begin
      tick();
      k++;
    end
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    in_data  = d;
    mode     = m;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [15:0] exp_d, input logic [3:0] exp_m);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_data"}, 32'(out_data), 32'(exp_d));
    check({tag, "_mask"}, 32'(out_err_mask), 32'(exp_m));
    check({tag, "_err"}, 32'(out_err), 32'(|exp_m));
  endtask

  task automatic release_result(input string tag, input logic [15:0] exp_d);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_idle"}, 32'(in_ready), 32'd1);
    check({tag, "_hold"}, 32'(out_data), 32'(exp_d));
  endtask

  task automatic do_word(input string tag, input logic [15:0] d, input logic m,
                         input logic [15:0] exp_d, input logic [3:0] exp_m);
    accept(tag, d, m);
    wait_result(tag, exp_d, exp_m);
    release_result(tag, exp_d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] sw_d [5];
    logic        sw_m [5];
    logic [19:0] exp_q [$];
    int          acc_q [$];
    logic [19:0] e;
    int          k;
    int          seen;
    int          cyc;
    int          last_acc;
    int          a;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    mode      = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_mask", 32'(out_err_mask), 32'd0);
    check("rst_err", 32'(out_err), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'd1);

    do_word("w1234", 16'h1234, 1'b0, 16'h4567, 4'b0000);
    do_word("w12a4", 16'h12A4, 1'b0, 16'h4507, 4'b0010);
    do_word("w4567", 16'h4567, 1'b1, 16'h1234, 4'b0000);
    do_word("w3d23", 16'h3D23, 1'b1, 16'h0000, 4'b0110);

    // Stall in DONE while junk is offered on the input side.
    accept("stall", 16'h0859, 1'b0);
    wait_result("stall", 16'h3B8C, 4'b0000);
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    mode     = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", 32'(out_data), 32'h3B8C);
      check("stall_mask", 32'(out_err_mask), 32'd0);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    release_result("stall", 16'h3B8C);

    // Reset mid-conversion aborts the word.
    accept("abort", 16'h1234, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("abort_ready", 32'(in_ready), 32'd1);
    check("abort_data", 32'(out_data), 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check("abort_no_valid", 32'(seen), 32'd0);
    do_word("w0909", 16'h0909, 1'b0, 16'h3C3C, 4'b0000);

    // Back-to-back stream with out_ready held high.
    sw_d[0] = 16'h9870; sw_m[0] = 1'b0;
    sw_d[1] = 16'hFA53; sw_m[1] = 1'b0;
    sw_d[2] = 16'hC3B6; sw_m[2] = 1'b1;
    sw_d[3] = 16'h0F12; sw_m[3] = 1'b1;
    sw_d[4] = 16'h5555; sw_m[4] = 1'b0;
    out_ready = 1'b1;
    k         = 0;
    seen      = 0;
    last_acc  = -1;
    cyc       = 0;
    while (seen < 5 && cyc < 80) begin
      if (out_valid) begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        check("stream_data", 32'(out_data), 32'(e[15:0]));
        check("stream_mask", 32'(out_err_mask), 32'(e[19:16]));
        check("stream_lat", 32'(cyc - a), 32'd4);
        seen++;
      end
      if (in_ready && k < 5) begin
        in_data  = sw_d[k];
        mode     = sw_m[k];
        in_valid = 1'b1;
        exp_q.push_back(ref_conv(sw_d[k], sw_m[k]));
        acc_q.push_back(cyc + 1);
        if (last_acc >= 0) check("stream_period", 32'(cyc + 1 - last_acc), 32'd6);
        last_acc = cyc + 1;
        k++;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    check("stream_count", 32'(seen), 32'd5);
    out_ready = 1'b0;
    in_valid  = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_ex3_serial_conv.md
BCD_EX3_SERIAL_CONV -- requirements
Module: bcd_ex3_serial_conv

Interface
REQ-001 SHALL have parameter DIGITS, default 4, giving the number of 4-bit digits per word; legal range is 1 to 16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: an input word is offered.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept a word.
REQ-006 SHALL have port in_data, input, 4*DIGITS bits: packed digits, digit 0 at bits [3:0].
REQ-007 SHALL have port mode, input, 1 bit: 0 converts BCD to Excess-3; 1 converts Excess-3 to BCD.
REQ-008 SHALL have port out_valid, output, 1 bit: a result word is presented.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 SHALL have port out_data, output, 4*DIGITS bits: the converted word, packed like in_data.
REQ-011 SHALL have port out_err_mask, output, DIGITS bits: bit i set means digit i was invalid.
REQ-012 SHALL have port out_err, output, 1 bit: OR-reduction of out_err_mask.

Function
REQ-013 SHALL implement the FSM states IDLE, CONV and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE, and 0 in CONV, DONE and while rst=1.
REQ-015 SHALL, in IDLE on in_valid&&in_ready, capture in_data and mode into internal registers, clear the digit index to 0, and go to CONV.
REQ-016 SHALL, in CONV, convert one digit per cycle from digit 0 up to digit DIGITS-1, writing the result and error bit into the out_data/out_err_mask slice for that digit.
REQ-017 SHALL, after the cycle that converts digit DIGITS-1, go to DONE; out_valid is then 1, exactly DIGITS cycles after the acceptance edge.
REQ-018 SHALL hold out_valid, out_data, out_err_mask and out_err stable in DONE while out_ready=0.
REQ-019 SHALL, in DONE on out_ready=1, go to IDLE and deassert out_valid; out_data and out_err_mask keep their last values.
REQ-020 SHALL ignore out_ready outside DONE, and ignore in_valid, in_data and mode outside IDLE.
REQ-021 SHALL, for mode 0, output d+3 for a digit d in 0..9 and flag d in 10..15 as invalid.
REQ-022 SHALL, for mode 1, output d-3 for a digit d in 3..12 and flag d in 0..2 and 13..15 as invalid.
REQ-023 SHALL output 4'h0 for every invalid digit, with its mask bit set to 1.
REQ-024 SHALL perform all digit arithmetic modulo 16 on 4 bits; no carry passes between digits.
REQ-025 SHALL size the digit index at max(1, $clog2(DIGITS)) bits, so that DIGITS=1 still works (one CONV cycle).
REQ-026 SHALL give a minimum period of DIGITS+2 cycles between accepted words when out_ready is held at 1.

Reset
REQ-027 SHALL, while rst=1, set state to IDLE, out_valid=0, out_data=0, out_err_mask=0, out_err=0, and the digit index to 0.
REQ-028 SHALL, when rst is asserted in CONV or DONE, abort the word in flight and produce no out_valid for it; in_ready is 1 on the first cycle after rst falls.

Structure
REQ-029 SHALL place the state enum, DIGIT_W=4, EX3_OFFSET=3 and the valid-range bounds (9, 3, 12) in a shared package named bcd_ex3_pkg.
REQ-030 SHALL use exactly one sub-module, ex3_digit_xlate: combinational, with 4-bit digit and mode in and 4-bit result and err out, instantiated once and shared across cycles.

Verification (DIGITS=4)
REQ-031 SHALL cover: in_data=16'h1234, mode 0 -> out_data=16'h4567, mask 4'b0000, out_valid 4 cycles after acceptance.
REQ-032 SHALL cover: in_data=16'h12A4, mode 0 -> out_data=16'h4507, mask 4'b0010, out_err=1.
REQ-033 SHALL cover: in_data=16'h4567, mode 1 -> 16'h1234; in_data=16'h3D23, mode 1 -> out_data=16'h0000, mask 4'b0110.
REQ-034 SHALL cover: out_ready held 0 for 5 cycles in DONE -> out_data stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-035 SHALL cover: rst pulsed for 1 cycle 2 cycles into CONV -> out_valid never rises for that word; a new word 16'h0909, mode 0 -> 16'h3C3C.
REQ-036 SHALL cover: a back-to-back stream with out_ready=1 -> one word per 6 cycles, all results matching a reference model.
